// File: rtl/bus_slave_decoder.sv
// bus_slave_decoder: decodes the top two master address bits to one of three
// slaves, sequences the request/ready/read-valid handshake and returns a
// one-cycle ack (with err for unmapped addresses) to the master. dsel is
// registered and only updates when a mapped request is accepted, so the
// downstream read-data mux stays stable after completion.
// Optional: define BUS_DECODER_TIMEOUT_EN to abort REQ/RESP after
// TIMEOUT_CYCLES cycles without progress (reported as an error ack).
module bus_slave_decoder #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m_req,
  input  logic [ADDR_WIDTH-1:0] m_addr,
  input  logic                  m_write,
  output logic                  m_ack,
  output logic                  m_err,
  output logic                  busy,
  output logic [2:0]            s_req,
  output logic [ADDR_WIDTH-3:0] s_addr,
  output logic                  s_write,
  input  logic [2:0]            s_ready,
  input  logic [2:0]            s_rvalid,
  output logic [1:0]            dsel
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_ACK,
    S_ERR
  } state_t;

  state_t                state_q, state_d;
  logic                  m_ack_q, m_ack_d;
  logic                  m_err_q, m_err_d;
  logic                  busy_q, busy_d;
  logic [2:0]            s_req_q, s_req_d;
  logic [ADDR_WIDTH-3:0] s_addr_q, s_addr_d;
  logic                  s_write_q, s_write_d;
  logic [1:0]            dsel_q, dsel_d;

  logic [1:0] idx;
  logic       sel_ready;
  logic       sel_rvalid;
  logic       expire;

  assign idx = m_addr[ADDR_WIDTH-1:ADDR_WIDTH-2];

  // Pick the handshake bits of the selected slave only; others are ignored.
  always_comb begin
    sel_ready  = 1'b0;
    sel_rvalid = 1'b0;
    case (dsel_q)
      2'd0: begin sel_ready = s_ready[0]; sel_rvalid = s_rvalid[0]; end
      2'd1: begin sel_ready = s_ready[1]; sel_rvalid = s_rvalid[1]; end
      2'd2: begin sel_ready = s_ready[2]; sel_rvalid = s_rvalid[2]; end
      default: begin sel_ready = 1'b0; sel_rvalid = 1'b0; end
    endcase
  end

`ifdef BUS_DECODER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Cycle counter: zero in IDLE (so REQ entry starts at 0), counts in REQ/RESP.
  always_comb begin
    cnt_d  = '0;
    expire = 1'b0;
    if (state_q == S_REQ || state_q == S_RESP) begin
      cnt_d  = cnt_q + CNT_W'(1);
      expire = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign expire = 1'b0;
`endif

  // Next-state and next-output logic; progress is checked before expiry.
  always_comb begin
    state_d   = state_q;
    s_req_d   = s_req_q;
    s_addr_d  = s_addr_q;
    s_write_d = s_write_q;
    dsel_d    = dsel_q;
    case (state_q)
      S_IDLE: begin
        if (m_req) begin
          s_addr_d  = m_addr[ADDR_WIDTH-3:0];
          s_write_d = m_write;
          if (idx != 2'b11) begin
            dsel_d  = idx;
            s_req_d = 3'b001 << idx;
            state_d = S_REQ;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_REQ: begin
        if (sel_ready) begin
          s_req_d = '0;
          state_d = s_write_q ? S_ACK : S_RESP;
        end else if (expire) begin
          s_req_d = '0;
          state_d = S_ERR;
        end
      end
      S_RESP: begin
        if (sel_rvalid)  state_d = S_ACK;
        else if (expire) state_d = S_ERR;
      end
      S_ACK:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    m_ack_d = (state_d == S_ACK) || (state_d == S_ERR);
    m_err_d = (state_d == S_ERR);
    busy_d  = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      m_ack_q   <= 1'b0;
      m_err_q   <= 1'b0;
      busy_q    <= 1'b0;
      s_req_q   <= '0;
      s_addr_q  <= '0;
      s_write_q <= 1'b0;
      dsel_q    <= '0;
    end else begin
      state_q   <= state_d;
      m_ack_q   <= m_ack_d;
      m_err_q   <= m_err_d;
      busy_q    <= busy_d;
      s_req_q   <= s_req_d;
      s_addr_q  <= s_addr_d;
      s_write_q <= s_write_d;
      dsel_q    <= dsel_d;
    end
  end

  assign m_ack   = m_ack_q;
  assign m_err   = m_err_q;
  assign busy    = busy_q;
  assign s_req   = s_req_q;
  assign s_addr  = s_addr_q;
  assign s_write = s_write_q;
  assign dsel    = dsel_q;

endmodule

// File: doc/bus_slave_decoder.md
Name: bus_slave_decoder

Overview:
- Address decoder and transaction sequencer placed upstream of the 3-way read-data mux.
- Accepts one master request at a time and decodes the top two address bits to a slave index.
- Drives a one-hot request to the selected slave and waits for its ready and, on reads, its read-valid.
- Produces the registered `dsel` that steers the read-data mux. Returns a one-cycle completion/error pulse to the master.

Parameters:
- `ADDR_WIDTH`, 16, master address width; bits `[ADDR_WIDTH-1:ADDR_WIDTH-2]` select the slave.
- `TIMEOUT_CYCLES`, 255, cycles allowed in REQ+RESP before abort (used only with the optional feature); minimum value 1.

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous reset, active-high
- `m_req`  in  1  master request strobe, sampled in IDLE only
- `m_addr`  in  ADDR_WIDTH  master address
- `m_write`  in  1  1 = write, 0 = read
- `m_ack`  out  1  one-cycle transaction-complete pulse
- `m_err`  out  1  one-cycle error flag, asserted only together with `m_ack`
- `busy`  out  1  high in every state except IDLE
- `s_req`  out  3  one-hot request to slave 0/1/2
- `s_addr`  out  ADDR_WIDTH-2  latched slave-local offset
- `s_write`  out  1  latched direction
- `s_ready`  in  3  per-slave request-accepted
- `s_rvalid`  in  3  per-slave read-data-valid
- `dsel`  out  2  slave index to the read-data mux

Behaviour:
- All outputs are registered. Reset values: `m_ack`=0, `m_err`=0, `busy`=0, `s_req`=000, `s_addr`=0, `s_write`=0, `dsel`=00, state=IDLE.
- `idx` = `m_addr[ADDR_WIDTH-1:ADDR_WIDTH-2]`.
  - 00, 01, 10 map to slaves 0, 1, 2.
  - 11 is unmapped.
- IDLE, when `m_req`=1:
  - Latch `s_addr` = `m_addr[ADDR_WIDTH-3:0]` and `s_write` = `m_write`.
  - If `idx` != 11: `dsel`<=`idx`, `s_req`<=onehot(`idx`), go to REQ.
  - If `idx` = 11: go to ERR; `dsel` is unchanged.
  - When `m_req`=0, IDLE holds.
- REQ: `s_req[dsel]` is held high. When `s_ready[dsel]`=1:
  - Clear `s_req`.
  - If write, go to ACK. If read, go to RESP.
- RESP: `s_req`=000. When `s_rvalid[dsel]`=1, go to ACK.
- ACK: `m_ack`=1 for exactly one cycle, then IDLE.
- ERR: `m_ack`=1 and `m_err`=1 for exactly one cycle, then IDLE. No slave is requested.
- `dsel` stability: `dsel` changes only on acceptance of a mapped request. It holds through ACK and all following IDLE cycles, so the mux output stays stable after completion.
- `s_ready` and `s_rvalid` bits of non-selected slaves are ignored in all states. `s_rvalid` is ignored outside RESP. `s_ready` is ignored outside REQ.
- `m_req` is ignored while `busy`=1. A request held high through the ACK cycle is accepted on the following IDLE cycle.
- Minimum latency:
  - Write: `m_req` sampled at cycle 0, `s_req` high at cycle 1; with `s_ready`=1 at cycle 1, `m_ack` is high at cycle 2.
  - Read: `s_rvalid` observed at cycle n gives `m_ack` at cycle n+1.
  - Unmapped: `m_ack`/`m_err` at cycle 1.
- Simultaneous `s_ready` and `s_rvalid` in REQ: only `s_ready` is acted on. The read then waits for `s_rvalid` in RESP.
- Reset in any state: on the next edge the block is in IDLE with all outputs at reset values, including `s_req`=000 and `dsel`=00. The in-flight transaction is abandoned with no `m_ack`.
- The block never issues back-to-back transactions. At least one IDLE cycle follows every ACK or ERR.

Optional Feature:
- Macro: `BUS_DECODER_TIMEOUT_EN`.
- Defined:
  - A counter clears on entry to REQ and increments each cycle in REQ or RESP.
  - When the counter reaches `TIMEOUT_CYCLES` without progress, `s_req` is cleared and the FSM goes to ERR (`m_ack`=1, `m_err`=1), then IDLE. `dsel` keeps the aborted index.
  - If progress and expiry coincide on the same cycle, progress wins.
- Undefined: no counter is present, and REQ and RESP wait indefinitely.

Test Plan:
- Write to slave 1: `m_addr`=0x4010, `m_write`=1, `s_ready[1]`=1 immediately.
  - Response: `s_req`=010 at cycle 1, `s_addr`=0x0010, `m_ack`=1 and `m_err`=0 at cycle 2, `dsel`=01 held afterwards.
- Read from slave 2: `m_addr`=0x8004, `s_ready[2]` at cycle 3, `s_rvalid[2]` at cycle 6.
  - Response: `s_req`=100 during cycles 1–3, `m_ack` at cycle 7, `dsel`=10 from cycle 1 onward.
- Unmapped address: `m_addr`=0xC000.
  - Response: `m_ack`=`m_err`=1 at cycle 1, `s_req` stays 000, `dsel` keeps its previous value.
- Wrong-slave handshake: read to slave 0 while `s_ready[1]`, `s_ready[2]`, `s_rvalid[1]` and `s_rvalid[2]` are pulsed.
  - Response: no state change until `s_ready[0]` and then `s_rvalid[0]` arrive.
- Mid-operation reset: `rst`=1 while in RESP.
  - Response: next cycle `busy`=0, `s_req`=000, `dsel`=00, and no `m_ack`. A new `m_req` is accepted normally afterwards.
- With `BUS_DECODER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4: request to slave 0 with `s_ready[0]` held low.
  - Response: `m_ack`=`m_err`=1 four cycles after REQ entry, and `s_req` is cleared.
